// File: rtl/fir_inverse_filter_if.sv
// Stream bundle for fir_inverse_filter: filtered samples in, recovered samples out.
// The slave modport is the filter's view; the master modport is the upstream/downstream side.
interface fir_inverse_filter_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] y_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x_out;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  y_in,
        input  in_valid,
        output in_ready,
        output x_out,
        output out_valid,
        input  out_ready
    );

    modport master (
        output y_in,
        output in_valid,
        input  in_ready,
        input  x_out,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fir_inverse_filter.sv
// fir_inverse_filter: streaming inverse of the fixed 4-tap FIR
//   y[n] = x[n] + (x[n-1]>>1) + (x[n-2]>>2) + (x[n-3]>>3)  (mod 2^WIDTH).
// Recovers x[n] = y[n] - (x[n-1]>>1) - (x[n-2]>>2) - (x[n-3]>>3) with a
// one-entry valid/ready output register.
// Optional feature macro: INVFIR_STATS_EN adds a saturating 16-bit
// accepted-sample counter on port sample_cnt.
module fir_inverse_filter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clr,
    fir_inverse_filter_if.slave     bus
`ifdef INVFIR_STATS_EN
    ,
    output logic [15:0]             sample_cnt
`endif
);

    localparam int unsigned CNT_W = 16;

    logic [WIDTH-1:0] h0_q, h1_q, h2_q;
    logic [WIDTH-1:0] h0_d, h1_d, h2_d;
    logic [WIDTH-1:0] x_out_q, x_out_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready_c;
    logic             accept_c;
    logic [WIDTH-1:0] x_new_c;

    // Ready when not clearing and the output slot is empty or draining this cycle.
    assign in_ready_c = !clr && (!out_valid_q || bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;

    // Inverse recursion; all terms WIDTH bits so the difference wraps naturally.
    assign x_new_c = bus.y_in - (h0_q >> 1) - (h1_q >> 2) - (h2_q >> 3);

    assign bus.in_ready  = in_ready_c;
    assign bus.x_out     = x_out_q;
    assign bus.out_valid = out_valid_q;

    // Next-state for history and output register: clr, then accept, then drain.
    always_comb begin
        h0_d        = h0_q;
        h1_d        = h1_q;
        h2_d        = h2_q;
        x_out_d     = x_out_q;
        out_valid_d = out_valid_q;
        if (clr) begin
            h0_d        = '0;
            h1_d        = '0;
            h2_d        = '0;
            x_out_d     = '0;
            out_valid_d = 1'b0;
        end else if (accept_c) begin
            x_out_d     = x_new_c;
            h0_d        = x_new_c;
            h1_d        = h0_q;
            h2_d        = h1_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath and handshake state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h0_q        <= '0;
            h1_q        <= '0;
            h2_q        <= '0;
            x_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            h0_q        <= h0_d;
            h1_q        <= h1_d;
            h2_q        <= h2_d;
            x_out_q     <= x_out_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef INVFIR_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accepted-sample count, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (accept_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
    end

    // Counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sample_cnt = cnt_q;
`endif

endmodule
